// File: rtl/blackjack_table_ctrl.sv
// Blackjack round controller: deals from an LFSR (or forced test card), runs player
// hit/stay, plays the dealer to the stand threshold, resolves and keeps tallies.
module blackjack_table_ctrl #(
  parameter int unsigned HAND_W       = 6,
  parameter int unsigned CARD_MAX     = 10,
  parameter int unsigned BUST_LIMIT   = 21,
  parameter int unsigned DEALER_STAND = 17,
  parameter int unsigned CNT_W        = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic              Clock,
  input  logic              resetn,
  input  logic              new_game,
  input  logic              hit,
  input  logic              stay,
  input  logic              test_mode,
  input  logic [3:0]        test_card,
  output logic [HAND_W-1:0] player_hand,
  output logic [HAND_W-1:0] dealer_hand,
  output logic              z_play,
  output logic              z_win,
  output logic              z_lose,
  output logic              z_push,
  output logic              z_bust,
  output logic              z_dbust,
  output logic              busy,
  output logic [CNT_W-1:0]  win_count,
  output logic [CNT_W-1:0]  loss_count
);

  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [3:0] {
    S_IDLE, S_DEAL, S_PLAY, S_DEALER, S_RESOLVE,
    S_WIN, S_LOSE, S_PUSH, S_BUST, S_DBUST
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         deal_cnt_q, deal_cnt_d;
  logic [HAND_W-1:0]  player_q, player_d;
  logic [HAND_W-1:0]  dealer_q, dealer_d;
  logic [CNT_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   loss_q, loss_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic               z_play_q, z_win_q, z_lose_q, z_push_q, z_bust_q, z_dbust_q, busy_q;
  logic               z_play_d, z_win_d, z_lose_d, z_push_d, z_bust_d, z_dbust_d, busy_d;
  logic [HAND_W-1:0]  card_c;
  logic [HAND_W-1:0]  player_sum_c;
  logic [HAND_W-1:0]  dealer_sum_c;

  // Card source and the two hand adders
  always_comb begin
    if (test_mode) card_c = HAND_W'(test_card);
    else           card_c = HAND_W'(lfsr_q % 16'(CARD_MAX)) + HAND_W'(1);
    player_sum_c = player_q + card_c;
    dealer_sum_c = dealer_q + card_c;
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
  end

  // Next state, hands and tallies; flags decode the next state so they register alongside it
  always_comb begin
    state_d    = state_q;
    deal_cnt_d = deal_cnt_q;
    player_d   = player_q;
    dealer_d   = dealer_q;
    win_d      = win_q;
    loss_d     = loss_q;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE, S_PUSH, S_BUST, S_DBUST: begin
        if (new_game) begin
          state_d    = S_DEAL;
          player_d   = '0;
          dealer_d   = '0;
          deal_cnt_d = '0;
        end
      end
      S_DEAL: begin
        if (deal_cnt_q[0]) dealer_d = dealer_sum_c;
        else               player_d = player_sum_c;
        deal_cnt_d = deal_cnt_q + 2'd1;
        if (deal_cnt_q == 2'd3) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (hit && !stay) begin
          player_d = player_sum_c;
          if (player_sum_c > HAND_W'(BUST_LIMIT)) begin
            state_d = S_BUST;
            if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
          end
        end else if (stay && !hit) begin
          state_d = S_DEALER;
        end
      end
      S_DEALER: begin
        if (dealer_q < HAND_W'(DEALER_STAND)) begin
          dealer_d = dealer_sum_c;
          if (dealer_sum_c > HAND_W'(BUST_LIMIT)) begin
            state_d = S_DBUST;
            if (win_q != '1) win_d = win_q + CNT_W'(1);
          end
        end else begin
          state_d = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        if (player_q > dealer_q) begin
          state_d = S_WIN;
          if (win_q != '1) win_d = win_q + CNT_W'(1);
        end else if (player_q < dealer_q) begin
          state_d = S_LOSE;
          if (loss_q != '1) loss_d = loss_q + CNT_W'(1);
        end else begin
          state_d = S_PUSH;
        end
      end
      default: state_d = S_IDLE;
    endcase

    z_play_d  = (state_d == S_PLAY);
    z_win_d   = (state_d == S_WIN);
    z_lose_d  = (state_d == S_LOSE);
    z_push_d  = (state_d == S_PUSH);
    z_bust_d  = (state_d == S_BUST);
    z_dbust_d = (state_d == S_DBUST);
    busy_d    = (state_d == S_DEAL) || (state_d == S_DEALER) || (state_d == S_RESOLVE);
  end

  always_ff @(posedge Clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_IDLE;
      deal_cnt_q <= '0;
      player_q   <= '0;
      dealer_q   <= '0;
      win_q      <= '0;
      loss_q     <= '0;
      lfsr_q     <= LFSR_SEED;
      z_play_q   <= 1'b0;
      z_win_q    <= 1'b0;
      z_lose_q   <= 1'b0;
      z_push_q   <= 1'b0;
      z_bust_q   <= 1'b0;
      z_dbust_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      deal_cnt_q <= deal_cnt_d;
      player_q   <= player_d;
      dealer_q   <= dealer_d;
      win_q      <= win_d;
      loss_q     <= loss_d;
      lfsr_q     <= lfsr_d;
      z_play_q   <= z_play_d;
      z_win_q    <= z_win_d;
      z_lose_q   <= z_lose_d;
      z_push_q   <= z_push_d;
      z_bust_q   <= z_bust_d;
      z_dbust_q  <= z_dbust_d;
      busy_q     <= busy_d;
    end
  end

  assign player_hand = player_q;
  assign dealer_hand = dealer_q;
  assign win_count   = win_q;
  assign loss_count  = loss_q;
  assign z_play      = z_play_q;
  assign z_win       = z_win_q;
  assign z_lose      = z_lose_q;
  assign z_push      = z_push_q;
  assign z_bust      = z_bust_q;
  assign z_dbust     = z_dbust_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_blackjack_table_ctrl.sv
// Bench for blackjack_table_ctrl: directed rounds with literal expectations, then
// randomized play checked every cycle against a round-level behavioural model.
module tb_blackjack_table_ctrl;

  localparam int HAND_W   = 6;
  localparam int CNT_W    = 2;
  localparam int CARD_MAX = 10;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  // model round phases
  localparam int PH_IDLE = 0, PH_DEAL = 1, PH_PLAY = 2, PH_DEALER = 3, PH_RESOLVE = 4,
                 PH_WIN = 5, PH_LOSE = 6, PH_PUSH = 7, PH_BUST = 8, PH_DBUST = 9;

  logic              Clock = 1'b0;
  logic              resetn;
  logic              new_game, hit, stay, test_mode;
  logic [3:0]        test_card;
  logic [HAND_W-1:0] player_hand, dealer_hand;
  logic              z_play, z_win, z_lose, z_push, z_bust, z_dbust, busy;
  logic [CNT_W-1:0]  win_count, loss_count;

  int          n_checks = 0;
  int          n_errors = 0;
  int          m_phase, m_p, m_d, m_win, m_loss, m_dealt;
  logic [15:0] m_lfsr;

  blackjack_table_ctrl #(.HAND_W(HAND_W), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .resetn(resetn), .new_game(new_game), .hit(hit), .stay(stay),
    .test_mode(test_mode), .test_card(test_card),
    .player_hand(player_hand), .dealer_hand(dealer_hand),
    .z_play(z_play), .z_win(z_win), .z_lose(z_lose), .z_push(z_push),
    .z_bust(z_bust), .z_dbust(z_dbust), .busy(busy),
    .win_count(win_count), .loss_count(loss_count)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bump(input int c);
    return (c < CNT_MAX) ? c + 1 : c;
  endfunction

  task automatic model_reset();
    m_phase = PH_IDLE; m_p = 0; m_d = 0; m_win = 0; m_loss = 0; m_dealt = 0;
    m_lfsr = 16'hACE1;
  endtask

  // One clock edge of the round rules
  task automatic model_step();
    int card;
    if (!resetn) begin
      model_reset();
      return;
    end
    card = test_mode ? int'(test_card) : int'(m_lfsr % 16'(CARD_MAX)) + 1;
    case (m_phase)
      PH_DEAL: begin
        if (m_dealt % 2 == 0) m_p += card; else m_d += card;
        m_dealt++;
        if (m_dealt == 4) m_phase = PH_PLAY;
      end
      PH_PLAY: begin
        if (hit && !stay) begin
          m_p += card;
          if (m_p > 21) begin m_phase = PH_BUST; m_loss = bump(m_loss); end
        end else if (stay && !hit) m_phase = PH_DEALER;
      end
      PH_DEALER: begin
        if (m_d < 17) begin
          m_d += card;
          if (m_d > 21) begin m_phase = PH_DBUST; m_win = bump(m_win); end
        end else m_phase = PH_RESOLVE;
      end
      PH_RESOLVE: begin
        if (m_p > m_d)      begin m_phase = PH_WIN;  m_win  = bump(m_win);  end
        else if (m_p < m_d) begin m_phase = PH_LOSE; m_loss = bump(m_loss); end
        else                m_phase = PH_PUSH;
      end
      default: begin
        if (new_game) begin m_phase = PH_DEAL; m_p = 0; m_d = 0; m_dealt = 0; end
      end
    endcase
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
  endtask

  task automatic compare_all();
    chk("player_hand", int'(player_hand), m_p);
    chk("dealer_hand", int'(dealer_hand), m_d);
    chk("z_play",  int'(z_play),  int'(m_phase == PH_PLAY));
    chk("z_win",   int'(z_win),   int'(m_phase == PH_WIN));
    chk("z_lose",  int'(z_lose),  int'(m_phase == PH_LOSE));
    chk("z_push",  int'(z_push),  int'(m_phase == PH_PUSH));
    chk("z_bust",  int'(z_bust),  int'(m_phase == PH_BUST));
    chk("z_dbust", int'(z_dbust), int'(m_phase == PH_DBUST));
    chk("busy", int'(busy), int'(m_phase == PH_DEAL || m_phase == PH_DEALER || m_phase == PH_RESOLVE));
    chk("win_count",  int'(win_count),  m_win);
    chk("loss_count", int'(loss_count), m_loss);
  endtask

  // Drive inputs at a falling edge, model the rising edge, compare at the next falling edge
  task automatic tick(input logic ng, input logic h, input logic s, input logic tm, input int tc);
    new_game = ng; hit = h; stay = s; test_mode = tm; test_card = 4'(tc);
    @(posedge Clock);
    model_step();
    @(negedge Clock);
    compare_all();
  endtask

  task automatic new_round(input int c0, input int c1, input int c2, input int c3);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, c0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, c1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, c2);
    tick(1'b0, 1'b0, 1'b0, 1'b1, c3);
  endtask

  task automatic pulse_reset();
    #2 resetn = 1'b0;
    model_reset();
    #1 compare_all();
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; new_game = 1'b0; hit = 1'b0; stay = 1'b0; test_mode = 1'b1; test_card = 4'd1;
    model_reset();
    @(negedge Clock);
    compare_all();
    chk("reset_player", int'(player_hand), 0);
    chk("reset_win", int'(win_count), 0);
    resetn = 1'b1;

    // round 1: stand on 20 vs 17 wins
    new_round(10, 7, 10, 10);
    chk("t1_player", int'(player_hand), 20);
    chk("t1_dealer", int'(dealer_hand), 17);
    chk("t1_play", int'(z_play), 1);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1);
    chk("t1_win", int'(z_win), 1);
    chk("t1_win_count", int'(win_count), 1);

    // round 2: hit on 20 busts
    new_round(10, 10, 10, 10);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 5);
    chk("t2_player", int'(player_hand), 25);
    chk("t2_bust", int'(z_bust), 1);
    chk("t2_loss_count", int'(loss_count), 1);

    // round 3: dealer draws from 12 and busts
    new_round(10, 6, 10, 6);
    chk("t3_dealer_pre", int'(dealer_hand), 12);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 10);
    chk("t3_dealer", int'(dealer_hand), 22);
    chk("t3_dbust", int'(z_dbust), 1);
    chk("t3_win_count", int'(win_count), 2);

    // round 4: 18 vs 18 push
    new_round(9, 10, 9, 8);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1);
    chk("t4_push", int'(z_push), 1);
    chk("t4_win_count", int'(win_count), 2);
    chk("t4_loss_count", int'(loss_count), 1);

    // round 5: hit&stay and new_game ignored in PLAY, then dealer reaches 20 and player loses
    new_round(5, 5, 5, 5);
    repeat (3) tick(1'b0, 1'b1, 1'b1, 1'b1, 9);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 9);
    chk("t5_player", int'(player_hand), 10);
    chk("t5_dealer", int'(dealer_hand), 10);
    chk("t5_play", int'(z_play), 1);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 10);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1);
    chk("t5_lose", int'(z_lose), 1);
    chk("t5_loss_count", int'(loss_count), 2);

    // round 6: reset while the dealer is drawing
    new_round(2, 2, 2, 2);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1);
    chk("t6_busy", int'(busy), 1);
    chk("t6_dealer", int'(dealer_hand), 5);
    #2 resetn = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_dealer", int'(dealer_hand), 0);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_win", int'(win_count), 0);
    chk("t6_rst_loss", int'(loss_count), 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1);
    resetn = 1'b1;

    // four wins saturate a 2-bit tally at 3
    repeat (4) begin
      new_round(10, 7, 10, 10);
      tick(1'b0, 1'b0, 1'b1, 1'b1, 1);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1);
      tick(1'b0, 1'b0, 1'b0, 1'b1, 1);
    end
    chk("sat_win_count", int'(win_count), 3);

    // randomized play, both card sources, occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) pulse_reset();
      else tick(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                int'($urandom_range(1, CARD_MAX)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
